// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the ALU arbiter slice:
//   - ALU_OP_W, XLEN, NREQ_MAX : datapath and configuration constants
//   - alu_op_t                 : all 16 op codes (10 ALU ops, 6 branch ops)
//   - is_branch_op()           : true for the branch-compare op codes
//
// Used by alu, rr_arbiter and alu_arbiter.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;
  localparam int XLEN     = 32;
  localparam int NREQ_MAX = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SLT  = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } alu_op_t;

  // Branch ops occupy the top six codes of the op space.
  function automatic logic is_branch_op(input alu_op_t op);
    return (op >= OP_BEQ);
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// Purely combinational 32-bit ALU shared by all requesters.
//
// Ports:
//   a, b    in  XLEN  operands
//   op      in  4     operation (alu_op_t)
//   result  out XLEN  operation result (0 for codes it does not implement)
//   zero    out 1     result == 0
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Branch codes are not ALU operations; they fall to the default and
  // produce 0, which the arbiter relies on when branch support is disabled.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter. The search starts one past the last granted index
// and wraps; the pointer only moves when a grant is actually issued.
//
// Ports:
//   clk        in  1              system clock, rising edge
//   rst_n      in  1              asynchronous active-low reset
//   req        in  NREQ           request vector
//   en         in  1              grants allowed this cycle
//   grant      out NREQ           one-hot grant (all zero when !en)
//   grant_idx  out $clog2(NREQ)   index of the round-robin winner
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the candidates in priority order: last_grant+1, +2, ... wrapping
  // at NREQ-1 (explicit wrap keeps non-power-of-two NREQ correct). The last
  // candidate visited is last_grant itself, so it has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Reset to NREQ-1 so requester 0 has top priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_IDX;
    end else if (|grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between NREQ requesters using round-robin arbitration.
// The winner's operands drive the ALU combinationally in the grant cycle;
// result, zero flag and requester id are registered into a single response
// slot that can be drained and refilled in the same cycle.
//
// Optional feature (macro ALU_ARB_BRANCH_EN): branch ops BEQ..BGEU are
// resolved to a taken bit using the same ALU (SUB / SLT / SLTU). Without
// the macro, branch codes reach the ALU unchanged and return 0.
//
// Parameters:
//   NREQ         number of requesters (2..4)
//
// Ports:
//   clk          in  1              system clock, rising edge
//   rst_n        in  1              asynchronous active-low reset
//   req_valid    in  NREQ           request present, per requester
//   req_ready    out NREQ           request accepted this cycle
//   req_a        in  NREQ*32        operand A, requester i at [i*32 +: 32]
//   req_b        in  NREQ*32        operand B, requester i at [i*32 +: 32]
//   req_op       in  NREQ*4         op code,   requester i at [i*4 +: 4]
//   resp_valid   out 1              response held
//   resp_ready   in  1              consumer takes response
//   resp_id      out $clog2(NREQ)   requester that issued the response
//   resp_result  out 32             ALU result, or taken bit for branches
//   resp_zero    out 1              zero flag of the registered result
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_a,
  input  logic [NREQ*XLEN-1:0]     req_b,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [XLEN-1:0]          resp_result,
  output logic                     resp_zero
);

  localparam int IDX_W = $clog2(NREQ);

  logic                can_issue;
  logic                accept;
  logic [IDX_W-1:0]    grant_idx;
  logic [XLEN-1:0]     sel_a;
  logic [XLEN-1:0]     sel_b;
  logic [ALU_OP_W-1:0] sel_op_bits;
  alu_op_t             req_op_t;
  alu_op_t             alu_op;
  logic [XLEN-1:0]     alu_result;
  logic                alu_zero;
  logic [XLEN-1:0]     next_result;
  logic                next_zero;

  // The response slot can take a new op if it is empty or being drained now.
  assign can_issue = !resp_valid || resp_ready;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (can_issue),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign accept = |req_ready;

  // One-hot AND-OR mux of the granted requester's operands.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_op_bits = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_a       = sel_a       | req_a[i*XLEN +: XLEN];
        sel_b       = sel_b       | req_b[i*XLEN +: XLEN];
        sel_op_bits = sel_op_bits | req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  assign req_op_t = alu_op_t'(sel_op_bits);

`ifdef ALU_ARB_BRANCH_EN
  logic taken;

  // Equality branches reuse SUB and the zero flag; ordered branches reuse
  // the set-less-than ops and read bit 0.
  always_comb begin
    alu_op = req_op_t;
    case (req_op_t)
      OP_BEQ,  OP_BNE:  alu_op = OP_SUB;
      OP_BLT,  OP_BGE:  alu_op = OP_SLT;
      OP_BLTU, OP_BGEU: alu_op = OP_SLTU;
      default:          alu_op = req_op_t;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (req_op_t)
      OP_BEQ:  taken = alu_zero;
      OP_BNE:  taken = !alu_zero;
      OP_BLT:  taken = alu_result[0];
      OP_BGE:  taken = !alu_result[0];
      OP_BLTU: taken = alu_result[0];
      OP_BGEU: taken = !alu_result[0];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (is_branch_op(req_op_t)) begin
      next_result = {{(XLEN-1){1'b0}}, taken};
      next_zero   = !taken;
    end else begin
      next_result = alu_result;
      next_zero   = alu_zero;
    end
  end
`else
  // Branch codes pass straight through; the ALU answers them with 0.
  assign alu_op      = req_op_t;
  assign next_result = alu_result;
  assign next_zero   = alu_zero;
`endif

  alu u_alu (
    .a      (sel_a),
    .b      (sel_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Response slot. A new accept overwrites the slot even when it is being
  // drained in the same cycle, so back-to-back ops see no bubble. Reset
  // discards any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_id     <= '0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_result <= next_result;
      resp_zero   <= next_zero;
      resp_id     <= grant_idx;
    end else if (resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule
